// File: rtl/pipe_control.sv
// LEGLite pipelined control: ID decode, ID/EX/MEM/WB control regs,
// load-use stall and CBZ flush resolved in MEM.
module pipe_control #(
  parameter int OPCODE_W  = 3,
  parameter int ALU_SEL_W = 3,
  parameter int REG_W     = 3,
  parameter int ALU_ADD   = 0,
  parameter int ALU_SUB   = 1,
  parameter int ALU_PASS  = 2,
  parameter int ALU_AND   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 nop,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_W-1:0]     id_rn,
  input  logic [REG_W-1:0]     id_rm,
  input  logic [REG_W-1:0]     id_rd,
  input  logic                 mem_zero,
  output logic                 reg2loc,
  output logic [ALU_SEL_W-1:0] ex_alu_select,
  output logic                 ex_alusrc,
  output logic                 mem_branch,
  output logic                 mem_memread,
  output logic                 mem_memwrite,
  output logic                 wb_memtoreg,
  output logic                 wb_regwrite,
  output logic                 pcsrc,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 ex_illegal
);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_CBZ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(7);

  typedef struct packed {
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 alusrc;
    logic                 branch;
    logic                 memread;
    logic                 memwrite;
    logic                 memtoreg;
    logic                 regwrite;
    logic                 illegal;
    logic [REG_W-1:0]     rd;
  } id_ex_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ex_mem_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } mem_wb_t;

  id_ex_t           dec;
  id_ex_t           ex_q;
  ex_mem_t          mem_q;
  mem_wb_t          wb_q;
  logic             rn_used;
  logic             s2_used;
  logic             r2l;
  logic [REG_W-1:0] s2;
  logic             hazard;
  logic             stall;

  always_comb begin
    dec     = '0;
    dec.rd  = id_rd;
    rn_used = 1'b0;
    s2_used = 1'b0;
    r2l     = 1'b0;
    if (!nop) begin
      unique case (1'b1)
        (opcode == OP_ADD): begin
          dec.alu_sel  = ALU_SEL_W'(ALU_ADD);
          dec.regwrite = 1'b1;
          rn_used      = 1'b1;
          s2_used      = 1'b1;
        end
        (opcode == OP_SUB): begin
          dec.alu_sel  = ALU_SEL_W'(ALU_SUB);
          dec.regwrite = 1'b1;
          rn_used      = 1'b1;
          s2_used      = 1'b1;
        end
        (opcode == OP_LD): begin
          dec.alusrc   = 1'b1;
          dec.memread  = 1'b1;
          dec.memtoreg = 1'b1;
          dec.regwrite = 1'b1;
          rn_used      = 1'b1;
        end
        (opcode == OP_ST): begin
          r2l          = 1'b1;
          dec.alusrc   = 1'b1;
          dec.memwrite = 1'b1;
          rn_used      = 1'b1;
          s2_used      = 1'b1;
        end
        (opcode == OP_CBZ): begin
          r2l          = 1'b1;
          dec.branch   = 1'b1;
          dec.alu_sel  = ALU_SEL_W'(ALU_PASS);
          s2_used      = 1'b1;
        end
        (opcode == OP_ADDI): begin
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          rn_used      = 1'b1;
        end
        (opcode == OP_ANDI): begin
          dec.alu_sel  = ALU_SEL_W'(ALU_AND);
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          rn_used      = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign s2      = r2l ? id_rd : id_rm;
  assign hazard  = ex_q.memread &
                   ((rn_used & (ex_q.rd == id_rn)) |
                    (s2_used & (ex_q.rd == s2)));
  assign pcsrc   = mem_q.branch & mem_zero;
  // A taken branch squashes the ID instruction, so its stall is moot
  assign stall   = hazard & ~pcsrc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (pcsrc | stall) ? '0 : dec;
      mem_q <= pcsrc ? '0 : '{branch:   ex_q.branch,
                              memread:  ex_q.memread,
                              memwrite: ex_q.memwrite,
                              memtoreg: ex_q.memtoreg,
                              regwrite: ex_q.regwrite};
      wb_q  <= '{memtoreg: mem_q.memtoreg,
                 regwrite: mem_q.regwrite};
    end
  end

  assign reg2loc       = r2l;
  assign ex_alu_select = ex_q.alu_sel;
  assign ex_alusrc     = ex_q.alusrc;
  assign ex_illegal    = ex_q.illegal;
  assign mem_branch    = mem_q.branch;
  assign mem_memread   = mem_q.memread;
  assign mem_memwrite  = mem_q.memwrite;
  assign wb_memtoreg   = wb_q.memtoreg;
  assign wb_regwrite   = wb_q.regwrite;
  assign pc_write      = ~stall;
  assign ifid_write    = ~stall;
  assign ifid_flush    = pcsrc;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed vector table, reset corners,
// and random stimulus against an instruction-level pipeline model.
module tb_pipe_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       nop = 1'b1;
  logic [2:0] opcode = '0;
  logic [2:0] id_rn = '0;
  logic [2:0] id_rm = '0;
  logic [2:0] id_rd = '0;
  logic       mem_zero = 1'b0;
  logic       reg2loc;
  logic [2:0] ex_alu_select;
  logic       ex_alusrc;
  logic       mem_branch;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       wb_memtoreg;
  logic       wb_regwrite;
  logic       pcsrc;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       ex_illegal;

  int checks = 0;
  int errors = 0;

  pipe_control dut (
    .clock(clock), .reset(reset), .nop(nop), .opcode(opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .mem_zero(mem_zero), .reg2loc(reg2loc),
    .ex_alu_select(ex_alu_select), .ex_alusrc(ex_alusrc),
    .mem_branch(mem_branch), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .wb_memtoreg(wb_memtoreg),
    .wb_regwrite(wb_regwrite), .pcsrc(pcsrc),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .ex_illegal(ex_illegal)
  );

  always #5 clock = ~clock;

  // {reg2loc, alu[3], alusrc, illegal, branch, memread,
  //  memwrite, memtoreg, regwrite, pcsrc, pc_w, ifid_w, flush}
  localparam logic [14:0] RST_VEC = 15'b000000000000110;

  typedef struct {
    logic       nop;
    logic [2:0] op, rn, rm, rd;
    logic       mz;
    logic       r2l;
    logic [2:0] alu;
    logic       src, ill, br, mrd, mwr, m2r, rw, pcs, pcw;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [14:0] dut_vec();
    return {reg2loc, ex_alu_select, ex_alusrc, ex_illegal,
            mem_branch, mem_memread, mem_memwrite,
            wb_memtoreg, wb_regwrite, pcsrc,
            pc_write, ifid_write, ifid_flush};
  endfunction

  task automatic check(input string name,
                       input logic [14:0] got,
                       input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // instruction-level reference: -1 = bubble, else opcode value
  function automatic bit legal(int op);
    return op inside {0, 1, 3, 4, 5, 6, 7};
  endfunction
  function automatic logic [2:0] alu_of(int op);
    return (op == 1) ? 3'd1 : (op == 5) ? 3'd2 :
           (op == 7) ? 3'd4 : 3'd0;
  endfunction
  function automatic bit uses_rn(int op);
    return op inside {0, 1, 3, 4, 6, 7};
  endfunction

  task automatic drive(input logic n, input logic [2:0] op,
                       input logic [2:0] rn, input logic [2:0] rm,
                       input logic [2:0] rd, input logic mz);
    nop = n; opcode = op; id_rn = rn;
    id_rm = rm; id_rd = rd; mem_zero = mz;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ex_op, mem_op, wb_op, id_op;
    logic [2:0] ex_rd;
    logic [14:0] exp;
    bit taken, haz, stall, hold;
    logic n; logic [2:0] op, rn, rm, rd; logic mz;

    tbl[0]  = '{0,0,1,2,3,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[1]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[2]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[3]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,1};
    tbl[4]  = '{0,3,1,0,2,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[5]  = '{0,0,2,4,5,0, 0,0,1,0,0,0,0,0,0,0,0};
    tbl[6]  = '{0,0,2,4,5,0, 0,0,0,0,0,1,0,0,0,0,1};
    tbl[7]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,1,1,0,1};
    tbl[8]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[9]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,1};
    tbl[10] = '{0,5,0,0,1,0, 1,0,0,0,0,0,0,0,0,0,1};
    tbl[11] = '{0,4,1,0,3,0, 1,2,0,0,0,0,0,0,0,0,1};
    tbl[12] = '{0,6,1,0,4,1, 0,0,1,0,1,0,0,0,0,1,1};
    tbl[13] = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[14] = '{0,2,1,1,1,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[15] = '{1,0,0,0,0,0, 0,0,0,1,0,0,0,0,0,0,1};
    tbl[16] = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[17] = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[18] = '{0,5,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,1};
    tbl[19] = '{0,3,0,0,6,0, 0,2,0,0,0,0,0,0,0,0,1};
    tbl[20] = '{0,7,6,0,1,1, 0,0,1,0,1,0,0,0,0,1,1};
    tbl[21] = '{1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    tbl[22] = '{0,5,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,1};
    tbl[23] = '{1,0,0,0,0,0, 0,2,0,0,0,0,0,0,0,0,1};
    tbl[24] = '{1,0,0,0,0,0, 0,0,0,0,1,0,0,0,0,0,1};

    #12;
    check("reset_state", dut_vec(), RST_VEC);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].nop, tbl[i].op, tbl[i].rn, tbl[i].rm,
            tbl[i].rd, tbl[i].mz);
      #3;
      exp = {tbl[i].r2l, tbl[i].alu, tbl[i].src, tbl[i].ill,
             tbl[i].br, tbl[i].mrd, tbl[i].mwr, tbl[i].m2r,
             tbl[i].rw, tbl[i].pcs, tbl[i].pcw, tbl[i].pcw,
             tbl[i].pcs};
      check($sformatf("vec%0d", i), dut_vec(), exp);
      @(posedge clock); #1;
    end

    // async reset with a load sitting in MEM
    drive(0, 3, 1, 0, 2, 0);
    @(posedge clock); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clock); #3;
    check("ld_in_mem", {14'd0, mem_memread}, 15'd1);
    reset = 1'b0;
    #1;
    check("async_reset", dut_vec(), RST_VEC);
    #2;
    reset = 1'b1;
    @(posedge clock); #1;

    ex_op = -1; mem_op = -1; wb_op = -1; ex_rd = '0;
    hold = 0;
    n = 1; op = 0; rn = 0; rm = 0; rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        n  = ($urandom % 8) == 0;
        op = 3'($urandom % 8);
        rn = 3'($urandom_range(0, 3));
        rm = 3'($urandom_range(0, 3));
        rd = 3'($urandom_range(0, 3));
      end
      mz = 1'($urandom % 2);
      drive(n, op, rn, rm, rd, mz);
      #3;
      id_op = n ? -1 : int'(op);
      taken = (mem_op == 5) && mz;
      haz = (ex_op == 3) &&
            ((uses_rn(id_op) && ex_rd == rn) ||
             (id_op inside {0, 1} && ex_rd == rm) ||
             (id_op inside {4, 5} && ex_rd == rd));
      stall = haz && !taken;
      exp = {id_op inside {4, 5}, alu_of(ex_op),
             ex_op inside {3, 4, 6, 7},
             ex_op >= 0 && !legal(ex_op),
             mem_op == 5, mem_op == 3, mem_op == 4,
             wb_op == 3, wb_op inside {0, 1, 3, 6, 7},
             taken, !stall, !stall, taken};
      check($sformatf("rand%0d", i), dut_vec(), exp);
      wb_op  = mem_op;
      mem_op = taken ? -1 : ex_op;
      if (taken || stall) ex_op = -1;
      else begin
        ex_op = id_op;
        ex_rd = rd;
      end
      hold = stall;
      @(posedge clock); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
